// File: rtl/booth_mul.sv
// Signed radix-4 Booth multiplier, WORD_LEN x WORD_LEN -> 2*WORD_LEN; define BOOTH_MUL_VALID_EN for i_valid/o_valid.
// Latency 2 cycles (operand register, product register), throughput one pair per cycle.
// No backpressure: a new operand pair is accepted every cycle with no handshake.
module booth_mul #(
  parameter int WORD_LEN = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef BOOTH_MUL_VALID_EN
  input  logic                  i_valid,
  output logic                  o_valid,
`endif
  input  logic [WORD_LEN-1:0]   i_multiplier,
  input  logic [WORD_LEN-1:0]   i_multiplicand,
  output logic [2*WORD_LEN-1:0] o_result
);

  localparam int PW = 2 * WORD_LEN;
  localparam int NDIG = WORD_LEN / 2;

  logic [WORD_LEN-1:0] mplier_q;
  logic [WORD_LEN-1:0] mcand_q;
  logic [WORD_LEN:0]   mplier_ext;
  logic [PW-1:0]       mcand_ext;
  logic [2:0]          digit;
  logic [PW-1:0]       mag;
  logic                neg;
  logic [PW-1:0]       pp;
  logic [PW-1:0]       sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      mplier_q <= i_multiplier;
      mcand_q  <= i_multiplicand;
    end
  end

  // Appended zero is b[-1], so digit i is the 3-bit window ending at bit 2i+2.
  assign mplier_ext = {mplier_q, 1'b0};
  assign mcand_ext  = {{WORD_LEN{mcand_q[WORD_LEN-1]}}, mcand_q};

  always_comb begin
    sum   = '0;
    digit = '0;
    mag   = '0;
    neg   = 1'b0;
    pp    = '0;
    for (int i = 0; i < NDIG; i++) begin
      digit = mplier_ext[2*i+2 -: 3];
      mag   = '0;
      neg   = 1'b0;
      case (digit)
        3'b001, 3'b010: mag = mcand_ext;
        3'b011:         mag = mcand_ext << 1;
        3'b100: begin
          mag = mcand_ext << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = mcand_ext;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      // Two's-complement negate: invert, then carry in.
      pp  = (mag ^ {PW{neg}}) + {{(PW-1){1'b0}}, neg};
      sum = sum + (pp << (2 * i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
    end else begin
      o_result <= sum;
    end
  end

`ifdef BOOTH_MUL_VALID_EN
  logic valid_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      valid_q <= i_valid;
      o_valid <= valid_q;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul.sv
// Directed and random checks of booth_mul at WORD_LEN = 8.
module tb_booth_mul;

  localparam int W = 8;

  logic                  i_clk;
  logic                  i_rst;
  logic signed [W-1:0]   i_multiplier;
  logic signed [W-1:0]   i_multiplicand;
  logic signed [2*W-1:0] o_result;
`ifdef BOOTH_MUL_VALID_EN
  logic                  i_valid;
  logic                  o_valid;
`endif

  int checks = 0;
  int errors = 0;

  booth_mul #(.WORD_LEN(W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
`ifdef BOOTH_MUL_VALID_EN
    .i_valid        (i_valid),
    .o_valid        (o_valid),
`endif
    .i_multiplier   (i_multiplier),
    .i_multiplicand (i_multiplicand),
    .o_result       (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ops(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    i_multiplier   = a;
    i_multiplicand = b;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    set_ops(8'sd5, 8'sd7);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (o_result !== 16'sd0) begin
        errors++;
        $display("FAIL reset_cycle%0d: got %0d expected 0", c, o_result);
      end
    end
  endtask

  task automatic test_latency();
    i_rst = 1'b0;
    set_ops(8'sd5, 8'sd7);
    tick();
    checks++;
    if (o_result !== 16'sd0) begin
      errors++;
      $display("FAIL latency_1edge: got %0d expected 0", o_result);
    end
    tick();
    checks++;
    if (o_result !== 16'sd35) begin
      errors++;
      $display("FAIL latency_2edge: got %0d expected 35", o_result);
    end
  endtask

  task automatic test_extremes();
    logic signed [W-1:0]   ta [4];
    logic signed [W-1:0]   tb [4];
    logic signed [2*W-1:0] te [4];
    ta[0] = -8'sd128; tb[0] = -8'sd128; te[0] = 16'sd16384;
    ta[1] = -8'sd128; tb[1] = 8'sd127;  te[1] = -16'sd16256;
    ta[2] = -8'sd1;   tb[2] = 8'sd1;    te[2] = -16'sd1;
    ta[3] = 8'sd0;    tb[3] = -8'sd77;  te[3] = 16'sd0;
    for (int k = 0; k < 4; k++) begin
      set_ops(ta[k], tb[k]);
      tick();
      tick();
      checks++;
      if (o_result !== te[k]) begin
        errors++;
        $display("FAIL extreme%0d (%0d*%0d): got %0d expected %0d", k, ta[k], tb[k], o_result, te[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_ops(8'sd3, 8'sd4);
    tick();
    set_ops(-8'sd6, 8'sd9);
    tick();
    checks++;
    if (o_result !== 16'sd12) begin
      errors++;
      $display("FAIL b2b_first: got %0d expected 12", o_result);
    end
    set_ops(8'sd127, 8'sd127);
    tick();
    checks++;
    if (o_result !== -16'sd54) begin
      errors++;
      $display("FAIL b2b_second: got %0d expected -54", o_result);
    end
    tick();
    checks++;
    if (o_result !== 16'sd16129) begin
      errors++;
      $display("FAIL b2b_third: got %0d expected 16129", o_result);
    end
  endtask

  task automatic test_hold();
    set_ops(-8'sd3, 8'sd5);
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_result !== -16'sd15) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %0d expected -15", c, o_result);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_ops(8'sd10, 8'sd10);
    tick();
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_result !== 16'sd0) begin
      errors++;
      $display("FAIL midrst_flush: got %0d expected 0", o_result);
    end
    set_ops(8'sd0, 8'sd0);
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_result !== 16'sd0) begin
        errors++;
        $display("FAIL midrst_after%0d: got %0d expected 0", c, o_result);
      end
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [2*W-1:0] exp_p;
    int                    ia;
    int                    ib;
    int                    prod;
`ifdef BOOTH_MUL_VALID_EN
    logic                  v;
`endif
    for (int n = 0; n < 1000; n++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ia = a;
      ib = b;
      prod  = ia * ib;
      exp_p = prod[2*W-1:0];
      set_ops(a, b);
`ifdef BOOTH_MUL_VALID_EN
      v       = 1'($urandom);
      i_valid = v;
`endif
      tick();
      tick();
      checks++;
      if (o_result !== exp_p) begin
        errors++;
        $display("FAIL random%0d (%0d*%0d): got %0d expected %0d", n, a, b, o_result, exp_p);
      end
`ifdef BOOTH_MUL_VALID_EN
      checks++;
      if (o_valid !== v) begin
        errors++;
        $display("FAIL random_valid%0d: got %b expected %b", n, o_valid, v);
      end
`endif
    end
  endtask

  initial begin
    i_rst = 1'b1;
    set_ops(8'sd0, 8'sd0);
`ifdef BOOTH_MUL_VALID_EN
    i_valid = 1'b0;
`endif
    #1;
    test_reset();
    test_latency();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 SHALL have parameter WORD_LEN, default 8: operand width in bits; legal values are even integers >= 4.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset; reset is synchronous and active-high.
REQ-004 SHALL have port i_multiplier, input, WORD_LEN bits: signed two's-complement multiplier.
REQ-005 SHALL have port i_multiplicand, input, WORD_LEN bits: signed two's-complement multiplicand.
REQ-006 SHALL have port o_result, output, 2*WORD_LEN bits: signed two's-complement product, registered.

Function
REQ-007 SHALL compute o_result = i_multiplier * i_multiplicand, exact and signed, for every operand pair, with no overflow.
- Covers the corner case -2^(W-1) * -2^(W-1) = 2^(2W-2).
REQ-008 SHALL use radix-4 Booth recoding of i_multiplier into WORD_LEN/2 digits.
- Digit i is taken from bits {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
REQ-009 SHALL map each Booth digit as follows:
- 000 or 111 -> 0
- 001 or 010 -> +M
- 011 -> +2M
- 100 -> -2M
- 101 or 110 -> -M
REQ-010 SHALL form partial product i as the selected value, sign-extended to 2*WORD_LEN bits and shifted left by 2i.
- Negation is done in two's complement: invert plus carry-in.
REQ-011 SHALL sum all partial products modulo 2^(2*WORD_LEN).
REQ-012 SHALL be a 2-stage pipeline:
- Stage 1: both operands registered on an edge.
- Stage 2: the product of those registered operands registered into o_result on the next edge.
REQ-013 SHALL have latency 2: operands stable before rising edge N appear on o_result after edge N+1 and hold until edge N+2.
REQ-014 SHALL accept a new operand pair every cycle (throughput 1 per cycle) with no handshake.
REQ-015 SHALL need no stall or hold logic: operands held constant for several cycles produce the same o_result from the second edge onward.
REQ-016 SHALL contain no combinational path from inputs to o_result.

Reset
REQ-017 SHALL clear all pipeline registers, including o_result, to 0 on any rising edge where i_rst = 1.
REQ-018 SHALL have reset override any in-flight operation: operands captured before reset never appear on o_result.
REQ-019 SHALL give the first valid product 2 edges after the first edge where i_rst = 0 with operands stable; the output before that is 0.

Configuration
REQ-020 SHALL support macro BOOTH_MUL_VALID_EN.
- When defined: adds input i_valid (1 bit) and output o_valid (1 bit).
- o_valid is i_valid delayed by 2 cycles through the same pipeline.
- o_valid resets to 0.
- o_result still updates every cycle, independent of i_valid.
REQ-021 SHALL, when BOOTH_MUL_VALID_EN is undefined, have no i_valid or o_valid ports, with arithmetic and latency unchanged.

Verification
REQ-022 SHALL cover reset: assert i_rst for 2 cycles with operands 5 and 7 -> o_result = 0 throughout reset.
REQ-023 SHALL cover latency: release reset, apply 5 * 7 -> o_result = 35 exactly 2 edges later, and not after 1 edge.
REQ-024 SHALL cover sign and extreme values:
- -128 * -128 -> 16384
- -128 * 127 -> -16256
- -1 * 1 -> -1
- 0 * -77 -> 0
REQ-025 SHALL cover back-to-back operation: pairs (3,4), (-6,9), (127,127) on consecutive cycles -> 12, -54, 16129 on consecutive cycles.
REQ-026 SHALL cover reset mid-pipeline: apply (10,10), assert i_rst on the next edge -> o_result stays 0 and 100 never appears.
REQ-027 SHALL cover random operation: 1000 random WORD_LEN=8 pairs, each held 2 cycles -> o_result matches the signed reference product every time; with BOOTH_MUL_VALID_EN defined, o_valid also tracks i_valid at a 2-cycle delay.
